// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_pkg
// Purpose : Shared widths, state encoding and constants for the sequential
//           restoring divider (seq_divider) and its step cell (div_step).
// Contents: DIVIDEND_W, DIVISOR_W, REM_W, CNT_W, DIV0_QUOTIENT, state_e
// Revision: 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    // One extra bit holds the shifted-in dividend bit before the trial subtract
    localparam int REM_W      = DIVISOR_W + 1;
    localparam int CNT_W      = 3;

    localparam logic [DIVIDEND_W-1:0] DIV0_QUOTIENT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module  : div_step
// Purpose : One restoring-division iteration. Trial-subtracts the divisor
//           from the shifted partial remainder; the borrow decides whether
//           the original value is restored and gives the quotient bit.
// Ports   : t        in  REM_W     shifted partial remainder
//           divisor  in  DIVISOR_W divisor
//           rem_next out REM_W     partial remainder after this step
//           q_bit    out 1         quotient bit produced by this step
// Revision: 1.0 - initial release
// ============================================================================
module div_step
    import div_pkg::*;
(
    input  logic [REM_W-1:0]     t,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [REM_W-1:0]     rem_next,
    output logic                 q_bit
);

    logic [REM_W:0] diff;
    logic           borrow;

    // Extra MSB of the difference is the borrow out of the 5-bit subtract
    assign diff     = (REM_W+1)'(t) - (REM_W+1)'(divisor);
    assign borrow   = diff[REM_W];
    assign q_bit    = ~borrow;
    assign rem_next = borrow ? t : diff[REM_W-1:0];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider
// Purpose : Sequential unsigned restoring divider, 8-bit dividend by 4-bit
//           divisor, one quotient bit per clock, start/busy/done handshake.
// Ports   : clk         in  1  system clock, rising edge
//           rst_n       in  1  asynchronous active-low reset
//           start       in  1  request, sampled only in IDLE
//           dividend    in  8  numerator, latched on accept
//           divisor     in  4  denominator, latched on accept
//           busy        out 1  high while iterating
//           done        out 1  one-cycle pulse, results valid
//           quotient    out 8  held until next accept
//           remainder   out 4  held until next accept
//           div_by_zero out 1  last operation had a zero divisor
// Revision: 1.0 - initial release
// ============================================================================
module seq_divider
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    state_e                state_q, state_d;
    logic [DIVIDEND_W-1:0] q_q, q_d;        // dividend shifting out, quotient shifting in
    logic [DIVISOR_W-1:0]  d_q, d_d;
    logic [REM_W-1:0]      r_q, r_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  dbz_q, dbz_d;

    logic [REM_W-1:0]      step_t;
    logic [REM_W-1:0]      step_rem;
    logic                  step_qbit;

    // r_q stays below the divisor, so its MSB is always zero and drops out here
    assign step_t = REM_W'({r_q, q_q[DIVIDEND_W-1]});

    div_step u_step (
        .t        (step_t),
        .divisor  (d_q),
        .rem_next (step_rem),
        .q_bit    (step_qbit)
    );

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        d_d         = d_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                // done_q high in IDLE only after the zero-divisor path; its
                // pulse must finish before the next operation is taken
                if (start && !done_q) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                r_d   = step_rem;
                q_d   = {q_q[DIVIDEND_W-2:0], step_qbit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(7)) begin
                    state_d     = DONE;
                    quotient_d  = {q_q[DIVIDEND_W-2:0], step_qbit};
                    remainder_d = step_rem[DIVISOR_W-1:0];
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                // Zero divisor: results and the done pulse come out one edge
                // after accept, i.e. on the exit from DONE
                if (d_q == '0) begin
                    quotient_d  = DIV0_QUOTIENT;
                    remainder_d = q_q[DIVISOR_W-1:0];
                    dbz_d       = 1'b1;
                    done_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            d_q         <= d_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
